led_periph: RTL and testbench

//   Memory-mapped LED peripheral that drives the board LED pins (led_o of top).

---
 rtl/led_periph.sv | 122 ++++++++++++
 tb/tb_led_periph.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/led_periph.sv
// LED peripheral: memory-mapped OUT/BLINK/TOGGLE/CNT registers on a
// request/ack bus, with a free-running blink timebase. Every output is
// registered, so no bus input reaches a port combinationally.
//
// Handshake: a request is sampled on a clock edge only when ack_o is low.
// At that edge any write commits and rdata_o captures the read value.
// ack_o is then high for exactly one cycle. A request still present during
// the ack cycle is ignored, so a held request completes every second cycle.
module led_periph #(
   parameter int FREQ       = 27_000_000,
   parameter int NLEDS      = 6,
   parameter int ACTIVE_LOW = 1
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic             req_i,
   input  logic             we_i,
   input  logic [3:0]       addr_i,
   input  logic [31:0]      wdata_i,
   output logic             ack_o,
   output logic [31:0]      rdata_o,
   output logic [NLEDS-1:0] led_o
);

   // Cycles per blink half-period, never less than one.
   localparam int HALF = ((FREQ / 2) > 1) ? (FREQ / 2) : 1;

   localparam logic [1:0] A_OUT    = 2'd0;
   localparam logic [1:0] A_BLINK  = 2'd1;
   localparam logic [1:0] A_TOGGLE = 2'd2;
   localparam logic [1:0] A_CNT    = 2'd3;

   localparam logic [NLEDS-1:0] LED_RST = (ACTIVE_LOW != 0) ? {NLEDS{1'b1}} : {NLEDS{1'b0}};

   logic [NLEDS-1:0] r_out;
   logic [NLEDS-1:0] r_blink;
   logic             r_phase;
   logic [31:0]      r_presc;
   logic [31:0]      r_cnt;
   logic             r_ack;
   logic [31:0]      r_rdata;
   logic [NLEDS-1:0] r_led;

   logic             w_access;
   logic [31:0]      w_rd_mux;
   logic [NLEDS-1:0] w_led_true;
   logic             w_wrap;
   logic             w_unused;

   // Only the word-select bits of the address and the low NLEDS data bits matter.
   assign w_unused = ^{addr_i[1:0], wdata_i};

   assign w_access   = req_i & ~r_ack;
   assign w_wrap     = (r_presc == 32'(HALF - 1));
   assign w_led_true = r_out ^ (r_blink & {NLEDS{r_phase}});

   // Read data selection; TOGGLE is write-only and reads as zero.
   always_comb begin
      w_rd_mux = 32'd0;
      case (addr_i[3:2])
         A_OUT:    w_rd_mux = 32'(r_out);
         A_BLINK:  w_rd_mux = 32'(r_blink);
         A_TOGGLE: w_rd_mux = 32'd0;
         A_CNT:    w_rd_mux = r_cnt;
         default:  w_rd_mux = 32'd0;
      endcase
   end

   // Bus side: ack toggle, register writes and registered read data.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_ack   <= 1'b0;
         r_rdata <= 32'd0;
         r_out   <= '0;
         r_blink <= '0;
      end else begin
         r_ack   <= w_access;
         r_rdata <= 32'd0;
         if (w_access) begin
            if (we_i) begin
               case (addr_i[3:2])
                  A_OUT:    r_out   <= wdata_i[NLEDS-1:0];
                  A_BLINK:  r_blink <= wdata_i[NLEDS-1:0];
                  A_TOGGLE: r_out   <= r_out ^ wdata_i[NLEDS-1:0];
                  default:  ;
               endcase
            end else begin
               r_rdata <= w_rd_mux;
            end
         end
      end
   end

   // Blink timebase: prescaler wraps every HALF cycles, flipping phase and counting.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_presc <= 32'd0;
         r_phase <= 1'b0;
         r_cnt   <= 32'd0;
      end else if (w_wrap) begin
         r_presc <= 32'd0;
         r_phase <= ~r_phase;
         r_cnt   <= r_cnt + 32'd1;
      end else begin
         r_presc <= r_presc + 32'd1;
      end
   end

   // Pad driver: blink-masked LED state with board polarity applied.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_led <= LED_RST;
      end else begin
         r_led <= (ACTIVE_LOW != 0) ? ~w_led_true : w_led_true;
      end
   end

   assign ack_o   = r_ack;
   assign rdata_o = r_rdata;
   assign led_o   = r_led;

endmodule

// File: tb/tb_led_periph.sv
// Bench for led_periph with FREQ=10 (half-period 5 cycles), six active-low LEDs.
module tb_led_periph;

  logic        clk_i;
  logic        rstn_i;
  logic        req_i;
  logic        we_i;
  logic [3:0]  addr_i;
  logic [31:0] wdata_i;
  logic        ack_o;
  logic [31:0] rdata_o;
  logic [5:0]  led_o;

  int checks;
  int errors;

  led_periph #(.FREQ(10), .NLEDS(6), .ACTIVE_LOW(1)) dut (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .req_i   (req_i),
    .we_i    (we_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .ack_o   (ack_o),
    .rdata_o (rdata_o),
    .led_o   (led_o)
  );

  // clock / reset
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic [5:0]  exp_led;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One bus access, started at a negedge; returns at a negedge with the bus idle.
  task automatic bus(input logic we, input logic [3:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd);
    req_i   = 1'b1;
    we_i    = we;
    addr_i  = addr;
    wdata_i = wd;
    @(posedge clk_i);
    @(negedge clk_i);
    check("ack_pulse", {31'd0, ack_o}, 32'd1);
    rd      = rdata_o;
    req_i   = 1'b0;
    we_i    = 1'b0;
    addr_i  = 4'd0;
    wdata_i = 32'd0;
    @(negedge clk_i);
    check("ack_drop", {31'd0, ack_o}, 32'd0);
    check("rdata_idle", rdata_o, 32'd0);
  endtask

  task automatic set_vec(input int i, input logic we, input logic [3:0] addr,
                         input logic [31:0] wd, input logic chk, input logic [31:0] erd,
                         input logic [5:0] eled);
    vecs[i].we      = we;
    vecs[i].addr    = addr;
    vecs[i].wdata   = wd;
    vecs[i].chk_rd  = chk;
    vecs[i].exp_rd  = erd;
    vecs[i].exp_led = eled;
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] cnt_a;
    logic [31:0] cnt_b;
    logic [5:0]  cur;
    logic [5:0]  prev;
    bit          seen;

    checks  = 0;
    errors  = 0;
    rstn_i  = 1'b0;
    req_i   = 1'b0;
    we_i    = 1'b0;
    addr_i  = 4'd0;
    wdata_i = 32'd0;

    // vectors: {we, addr, wdata, check rdata, expected rdata, expected led after access}
    set_vec(0,  1'b0, 4'h0, 32'h0,        1'b1, 32'h00, 6'h3F);
    set_vec(1,  1'b1, 4'h0, 32'h15,       1'b0, 32'h00, 6'h2A);
    set_vec(2,  1'b0, 4'h0, 32'h0,        1'b1, 32'h15, 6'h2A);
    set_vec(3,  1'b1, 4'h8, 32'h3F,       1'b0, 32'h00, 6'h15);
    set_vec(4,  1'b0, 4'h0, 32'h0,        1'b1, 32'h2A, 6'h15);
    set_vec(5,  1'b0, 4'h8, 32'h0,        1'b1, 32'h00, 6'h15);
    set_vec(6,  1'b1, 4'h0, 32'hFFFFFFC0, 1'b0, 32'h00, 6'h3F);
    set_vec(7,  1'b0, 4'h0, 32'h0,        1'b1, 32'h00, 6'h3F);
    set_vec(8,  1'b1, 4'h4, 32'hFFFFFFC0, 1'b0, 32'h00, 6'h3F);
    set_vec(9,  1'b0, 4'h4, 32'h0,        1'b1, 32'h00, 6'h3F);
    set_vec(10, 1'b1, 4'h1, 32'h3F,       1'b0, 32'h00, 6'h00);
    set_vec(11, 1'b0, 4'h3, 32'h0,        1'b1, 32'h3F, 6'h00);
    set_vec(12, 1'b1, 4'h8, 32'h21,       1'b0, 32'h00, 6'h21);
    set_vec(13, 1'b0, 4'h0, 32'h0,        1'b1, 32'h1E, 6'h21);

    // reset held 40ns
    repeat (3) @(negedge clk_i);
    check("rst_led", {26'd0, led_o}, 32'h3F);
    check("rst_ack", {31'd0, ack_o}, 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    @(negedge clk_i);
    rstn_i = 1'b1;

    // table-driven register accesses (BLINK is zero, so phase does not matter)
    for (int i = 0; i < 14; i++) begin
      bus(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd);
      if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_led", i), {26'd0, led_o}, {26'd0, vecs[i].exp_led});
    end

    // blink: OUT=0, BLINK=3 -> led[1:0] alternate every 5 cycles, [5:2] stay 1111
    bus(1'b1, 4'h0, 32'h0, rd);
    bus(1'b1, 4'h4, 32'h3, rd);
    prev = led_o;
    seen = 1'b0;
    for (int t = 0; t < 12 && !seen; t++) begin
      @(negedge clk_i);
      if (led_o != prev) seen = 1'b1;
    end
    check("blink_edge_seen", {31'd0, seen}, 32'd1);
    for (int p = 0; p < 3; p++) begin
      cur = led_o;
      check("blink_level", {31'd0, (cur == 6'h3F) || (cur == 6'h3C)}, 32'd1);
      repeat (4) begin
        @(negedge clk_i);
        check("blink_hold", {26'd0, led_o}, {26'd0, cur});
      end
      @(negedge clk_i);
      check("blink_flip", {26'd0, led_o}, {26'd0, cur ^ 6'h03});
    end

    // CNT: read, ignored write, read again exactly 10 cycles after the first sample
    bus(1'b0, 4'hC, 32'h0, cnt_a);
    bus(1'b1, 4'hC, 32'h1234, rd);
    repeat (6) @(negedge clk_i);
    bus(1'b0, 4'hC, 32'h0, cnt_b);
    check("cnt_step", cnt_b, cnt_a + 32'd2);

    // clear BLINK while phase=1: LED returns to OUT and stops blinking
    seen = 1'b0;
    for (int t = 0; t < 12 && !seen; t++) begin
      @(negedge clk_i);
      if (led_o[1:0] == 2'b11) seen = 1'b1;
    end
    check("wait_phase0", {31'd0, seen}, 32'd1);
    seen = 1'b0;
    for (int t = 0; t < 12 && !seen; t++) begin
      @(negedge clk_i);
      if (led_o[1:0] == 2'b00) seen = 1'b1;
    end
    check("wait_phase1", {31'd0, seen}, 32'd1);
    bus(1'b1, 4'h4, 32'h0, rd);
    check("blink_clear_led", {26'd0, led_o}, 32'h3F);
    repeat (7) @(negedge clk_i);
    check("blink_clear_hold", {26'd0, led_o}, 32'h3F);

    // held request: ack 0,1,0,1,0,1 then async reset in the ack cycle
    req_i   = 1'b1;
    we_i    = 1'b1;
    addr_i  = 4'h0;
    wdata_i = 32'h0A;
    check("held_ack0", {31'd0, ack_o}, 32'd0);
    for (int c = 1; c < 6; c++) begin
      @(negedge clk_i);
      check($sformatf("held_ack%0d", c), {31'd0, ack_o}, {31'd0, c[0]});
    end
    check("held_led", {26'd0, led_o}, 32'h35);
    rstn_i = 1'b0;
    #1;
    check("rst_mid_ack", {31'd0, ack_o}, 32'd0);
    check("rst_mid_rdata", rdata_o, 32'd0);
    check("rst_mid_led", {26'd0, led_o}, 32'h3F);
    req_i   = 1'b0;
    we_i    = 1'b0;
    wdata_i = 32'd0;
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(negedge clk_i);
    bus(1'b0, 4'h0, 32'h0, rd);
    check("rst_mid_out", rd, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
